// File: rtl/cia_bus_cycle.sv
`default_nettype none
// ============================================================================
//  Module   : cia_bus_cycle
//  Purpose  : Turns a decoded CPU request for CIA space into a 68000-style
//             synchronous E-cycle. The chip selects are held for one full
//             E period, starting and ending on CLKCIA falling edges. Read
//             data is captured at the closing falling edge and a one-clock
//             acknowledge goes back to the bus controller.
//
//  Ports    : CLK7      in   7 MHz system clock (only clock)
//             RESET     in   asynchronous, active-high reset
//             CLKCIA    in   E clock (10 CLK7 periods, 4 high / 6 low),
//                            generated in the CLK7 domain
//             CIA_REQ   in   level request, held until CIA_ACK
//             RnW       in   1 = read, 0 = write (captured at acceptance)
//             A12       in   0 selects CIAA
//             A13       in   0 selects CIAB
//             CIA_DIN   in   [7:0] CIA read data
//             _CS_CIAA  out  CIAA chip select, active low
//             _CS_CIAB  out  CIAB chip select, active low
//             CIA_RnW   out  R/W strobe towards the CIAs
//             CIA_ACK   out  cycle-complete pulse, one CLK7 wide
//             CIA_DOUT  out  [7:0] last read data
//             CIA_ERR   out  timeout flag, pulses together with CIA_ACK
//
//  Options  : `define CIA_TIMEOUT_EN adds a watchdog that aborts the cycle
//             when CLKCIA shows no edge for TIMEOUT_CYCLES CLK7 cycles.
//             Without it the block waits indefinitely and CIA_ERR is 0.
//
//  Revision : 1.0  initial release
// ============================================================================
module cia_bus_cycle #(
  parameter int TIMEOUT_CYCLES = 63
) (
  input  logic       CLK7,
  input  logic       RESET,
  input  logic       CLKCIA,
  input  logic       CIA_REQ,
  input  logic       RnW,
  input  logic       A12,
  input  logic       A13,
  input  logic [7:0] CIA_DIN,
  output logic       _CS_CIAA,
  output logic       _CS_CIAB,
  output logic       CIA_RnW,
  output logic       CIA_ACK,
  output logic [7:0] CIA_DOUT,
  output logic       CIA_ERR
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [2:0] c_st_idle      = 3'd0;
  localparam logic [2:0] c_st_wait_fall = 3'd1;
  localparam logic [2:0] c_st_assert    = 3'd2;
  localparam logic [2:0] c_st_data      = 3'd3;
  localparam logic [2:0] c_st_wait_rel  = 3'd4;

  logic [2:0] r_state;

  // Request attributes captured at acceptance; later input changes are
  // ignored for the rest of the cycle.
  logic       r_a12;
  logic       r_a13;
  logic       r_rnw;

  // Registered bus outputs
  logic       r_cs_a_n;
  logic       r_cs_b_n;
  logic       r_cia_rnw;
  logic       r_ack;
  logic [7:0] r_dout;

  // E clock edge detection
  logic       r_clkcia_q;
  logic       w_fall;
  logic       w_rise;

  // Watchdog abort request (constant 0 when the watchdog is not built)
  logic       w_timeout;

  // --------------------------------------------------------------------------
  // CLKCIA comes from the same CLK7 domain, so a single register is enough
  // to see its edges without a synchroniser.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK7 or posedge RESET) begin
    if (RESET) begin
      r_clkcia_q <= 1'b0;
    end else begin
      r_clkcia_q <= CLKCIA;
    end
  end

  assign w_fall = r_clkcia_q & ~CLKCIA;
  assign w_rise = ~r_clkcia_q & CLKCIA;

  // --------------------------------------------------------------------------
  // Bus cycle sequencer
  //
  // The selects are registered on the fall that moves WAIT_FALL->ASSERT and
  // released on the next fall in DATA, which makes them exactly one E period
  // long. A fall seen on the same edge the request is accepted belongs to
  // IDLE and is therefore skipped; the cycle starts on the following fall.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK7 or posedge RESET) begin
    if (RESET) begin
      r_state   <= c_st_idle;
      r_a12     <= 1'b1;
      r_a13     <= 1'b1;
      r_rnw     <= 1'b1;
      r_cs_a_n  <= 1'b1;
      r_cs_b_n  <= 1'b1;
      r_cia_rnw <= 1'b1;
      r_ack     <= 1'b0;
      r_dout    <= 8'h00;
    end else begin
      r_ack <= 1'b0;

      if (w_timeout) begin
        // Watchdog abort: release the bus and report completion so the CPU
        // is not stalled forever. Read data is left untouched.
        r_cs_a_n  <= 1'b1;
        r_cs_b_n  <= 1'b1;
        r_cia_rnw <= 1'b1;
        r_ack     <= 1'b1;
        r_state   <= c_st_wait_rel;
      end else begin
        case (r_state)
          c_st_idle: begin
            if (CIA_REQ) begin
              r_a12   <= A12;
              r_a13   <= A13;
              r_rnw   <= RnW;
              r_state <= c_st_wait_fall;
            end
          end

          c_st_wait_fall: begin
            if (w_fall) begin
              r_cs_a_n  <= r_a12;
              r_cs_b_n  <= r_a13;
              r_cia_rnw <= r_rnw;
              r_state   <= c_st_assert;
            end
          end

          c_st_assert: begin
            if (w_rise) begin
              r_state <= c_st_data;
            end
          end

          c_st_data: begin
            if (w_fall) begin
              if (r_rnw) begin
                r_dout <= CIA_DIN;
              end
              r_ack     <= 1'b1;
              r_cs_a_n  <= 1'b1;
              r_cs_b_n  <= 1'b1;
              r_cia_rnw <= 1'b1;
              r_state   <= c_st_wait_rel;
            end
          end

          c_st_wait_rel: begin
            // A request still held high must not start a second cycle.
            if (!CIA_REQ) begin
              r_state <= c_st_idle;
            end
          end

          default: begin
            r_cs_a_n  <= 1'b1;
            r_cs_b_n  <= 1'b1;
            r_cia_rnw <= 1'b1;
            r_state   <= c_st_idle;
          end
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Optional CLKCIA watchdog
  // --------------------------------------------------------------------------
`ifdef CIA_TIMEOUT_EN
  localparam int              c_cnt_w   = $clog2(TIMEOUT_CYCLES + 1);
  // The abort fires on the edge that would take the count to TIMEOUT_CYCLES.
  localparam logic [c_cnt_w-1:0] c_to_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

  logic [c_cnt_w-1:0] r_to_cnt;
  logic               r_err;
  logic               w_active;
  logic               w_any_edge;

  assign w_active   = (r_state == c_st_wait_fall) ||
                      (r_state == c_st_assert)    ||
                      (r_state == c_st_data);
  assign w_any_edge = w_rise | w_fall;
  assign w_timeout  = w_active && !w_any_edge && (r_to_cnt == c_to_last);

  always_ff @(posedge CLK7 or posedge RESET) begin
    if (RESET) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= w_timeout;
      if (((r_state == c_st_idle) && CIA_REQ) || w_any_edge) begin
        r_to_cnt <= '0;
      end else if (w_active && !w_timeout) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

  assign CIA_ERR = r_err;
`else
  // Keeps TIMEOUT_CYCLES referenced in the build without the watchdog.
  localparam int c_unused_timeout = TIMEOUT_CYCLES;

  assign w_timeout = 1'b0;
  assign CIA_ERR   = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign _CS_CIAA = r_cs_a_n;
  assign _CS_CIAB = r_cs_b_n;
  assign CIA_RnW  = r_cia_rnw;
  assign CIA_ACK  = r_ack;
  assign CIA_DOUT = r_dout;

endmodule
`default_nettype wire
